therm_count_monitor: RTL and testbench



---
 rtl/therm_count_monitor_if.sv | 27 ++
 rtl/therm_count_monitor.sv | 149 ++++++++++++++
 tb/tb_therm_count_monitor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/therm_count_monitor_if.sv
// Bundle between the modulo counter's thermometric display bus and the monitor that checks it.
// Signal suffixes follow the monitor's view: _i is driven by the counter side, _o by the monitor.
interface therm_count_monitor_if #(
    parameter int N = 16
);
    localparam int W = $clog2(N);

    logic [N-1:0] tCount_i;
    logic         clrErr_i;
    logic [W-1:0] binCount_o;
    logic [1:0]   dir_o;
    logic         wrap_o;
    logic         turn_o;
    logic         err_o;
    logic         errFlag_o;
    logic [7:0]   errCnt_o;

    modport master (
        output tCount_i, clrErr_i,
        input  binCount_o, dir_o, wrap_o, turn_o, err_o, errFlag_o, errCnt_o
    );

    modport slave (
        input  tCount_i, clrErr_i,
        output binCount_o, dir_o, wrap_o, turn_o, err_o, errFlag_o, errCnt_o
    );
endinterface

// File: rtl/therm_count_monitor.sv
// Samples a thermometric count once per divider tick, decodes it to binary, validates the code
// and classifies each step as hold/up/down/jump with wrap, turnaround and error reporting.
module therm_count_monitor #(
    parameter int N   = 16,
    parameter int DIV = 100000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    therm_count_monitor_if.slave  bus
);
    localparam int         W    = $clog2(N);
    localparam int         DIVW = 27;
    localparam logic [W-1:0] MAXV = W'(N - 1);

    typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_UP, ST_DOWN} state_t;
    typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_JUMP} step_t;

    state_t          state_q, state_d;
    logic [DIVW-1:0] divCnt_q, divCnt_d;
    logic [W-1:0]    binCount_q, binCount_d;
    logic [1:0]      dir_q, dir_d;
    logic            wrap_q, wrap_d;
    logic            turn_q, turn_d;
    logic            err_q, err_d;
    logic            errFlag_q, errFlag_d;
    logic [7:0]      errCnt_q, errCnt_d;

    logic            tick;
    logic            codeValid;
    logic [W-1:0]    codeVal;
    logic [N-1:0]    mask;
    step_t           step;
    logic            isWrap;

    assign tick     = (divCnt_q == DIVW'(DIV - 1));
    assign divCnt_d = tick ? '0 : divCnt_q + DIVW'(1);

    // Only the N contiguous-from-bit-0 patterns are legal; all-ones is deliberately excluded.
    always_comb begin
        codeValid = 1'b0;
        codeVal   = '0;
        mask      = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.tCount_i == mask) begin
                codeValid = 1'b1;
                codeVal   = W'(k);
            end
            mask = {mask[N-2:0], 1'b1};
        end
    end

    always_comb begin
        step   = STEP_JUMP;
        isWrap = 1'b0;
        if (codeVal == binCount_q) begin
            step = STEP_HOLD;
        end else if (binCount_q == MAXV && codeVal == '0) begin
            step   = STEP_UP;
            isWrap = 1'b1;
        end else if (binCount_q == '0 && codeVal == MAXV) begin
            step   = STEP_DOWN;
            isWrap = 1'b1;
        end else if (codeVal == binCount_q + W'(1)) begin
            step = STEP_UP;
        end else if (codeVal == binCount_q - W'(1)) begin
            step = STEP_DOWN;
        end
    end

    // The error clear is applied before a same-cycle invalid sample so that sample still counts.
    always_comb begin
        state_d    = state_q;
        binCount_d = binCount_q;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
        turn_d     = 1'b0;
        err_d      = 1'b0;
        errFlag_d  = errFlag_q;
        errCnt_d   = errCnt_q;

        if (bus.clrErr_i) begin
            errFlag_d = 1'b0;
            errCnt_d  = '0;
        end

        if (tick) begin
            if (!codeValid) begin
                err_d     = 1'b1;
                errFlag_d = 1'b1;
                if (errCnt_d != 8'hFF) begin
                    errCnt_d = errCnt_d + 8'd1;
                end
            end else if (state_q == ST_SYNC) begin
                binCount_d = codeVal;
                dir_d      = 2'd0;
                state_d    = ST_HOLD;
            end else begin
                binCount_d = codeVal;
                dir_d      = step;
                case (step)
                    STEP_UP: begin
                        state_d = ST_UP;
                        wrap_d  = isWrap;
                        turn_d  = (state_q == ST_DOWN);
                    end
                    STEP_DOWN: begin
                        state_d = ST_DOWN;
                        wrap_d  = isWrap;
                        turn_d  = (state_q == ST_UP);
                    end
                    STEP_JUMP: state_d = ST_HOLD;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            divCnt_q   <= '0;
            binCount_q <= '0;
            dir_q      <= '0;
            wrap_q     <= 1'b0;
            turn_q     <= 1'b0;
            err_q      <= 1'b0;
            errFlag_q  <= 1'b0;
            errCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            binCount_q <= binCount_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
            turn_q     <= turn_d;
            err_q      <= err_d;
            errFlag_q  <= errFlag_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign bus.binCount_o = binCount_q;
    assign bus.dir_o      = dir_q;
    assign bus.wrap_o     = wrap_q;
    assign bus.turn_o     = turn_q;
    assign bus.err_o      = err_q;
    assign bus.errFlag_o  = errFlag_q;
    assign bus.errCnt_o   = errCnt_q;
endmodule

// File: tb/tb_therm_count_monitor.sv
// Directed bench for therm_count_monitor with a 4-cycle sample divider.
// Expected values are hand-derived per scenario; a bench-side divider locates each sample tick.
module tb_therm_count_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   tbDiv;

    therm_count_monitor_if #(.N(16)) bus();

    therm_count_monitor #(.N(16), .DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Tracks where the design's divider should be so stimulus can land on tick cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbDiv <= 0;
        else        tbDiv <= (tbDiv == 3) ? 0 : tbDiv + 1;
    end

    function automatic logic [15:0] therm(input int k);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < k; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Advances to just after the clock edge that ends the next tick cycle.
    task automatic waitTick();
        int n;
        n = 0;
        while (tbDiv != 3 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 8) begin
            tests++; fails++;
            $display("[TB] FAIL tick_timeout: divider value %0d required 3", tbDiv);
        end
        @(posedge clk); #1;
    endtask

    // Applies one code and checks {bin, dir, wrap, turn, err} right after its tick.
    task automatic applyStimulus(input string name, input logic [15:0] code,
                                 input logic [3:0] expBin, input logic [1:0] expDir,
                                 input logic expWrap, input logic expTurn, input logic expErr);
        logic [8:0] got, exp;
        bus.tCount_i = code;
        waitTick();
        got = {bus.binCount_o, bus.dir_o, bus.wrap_o, bus.turn_o, bus.err_o};
        exp = {expBin, expDir, expWrap, expTurn, expErr};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: bin/dir/wrap/turn/err got %0d/%0d/%b/%b/%b required %0d/%0d/%b/%b/%b",
                     name, got[8:5], got[4:3], got[2], got[1], got[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic test_reset();
        bus.tCount_i = 16'h0000;
        bus.clrErr_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.binCount_o, bus.dir_o, bus.wrap_o, bus.turn_o, bus.err_o, bus.errFlag_o, bus.errCnt_o} !== 19'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got bin %0d dir %0d flag %b cnt %0d required all 0",
                     bus.binCount_o, bus.dir_o, bus.errFlag_o, bus.errCnt_o);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_sync_and_up_wrap();
        applyStimulus("sync_first",  therm(3),  4'd3,  2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("hold_step",   therm(3),  4'd3,  2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("up_step",     therm(4),  4'd4,  2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("jump_to_13",  therm(13), 4'd13, 2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("up_14",       16'h3FFF,  4'd14, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("up_15",       16'h7FFF,  4'd15, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("up_wrap_0",   16'h0000,  4'd0,  2'd1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        tests++;
        if (bus.wrap_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_pulse_width: got %b required 0", bus.wrap_o);
        end
    endtask

    task automatic test_bounce();
        applyStimulus("bounce_jump",  16'h3FFF, 4'd14, 2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("bounce_up",    16'h7FFF, 4'd15, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("bounce_down",  16'h3FFF, 4'd14, 2'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus("down_again",   therm(13), 4'd13, 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus("jump_to_0",    16'h0000, 4'd0,  2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("down_wrap",    16'h7FFF, 4'd15, 2'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus("up_wrap_turn", 16'h0000, 4'd0,  2'd1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_error();
        applyStimulus("load_5",      therm(5), 4'd5, 2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("bubble",      16'h0005, 4'd5, 2'd3, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({bus.errFlag_o, bus.errCnt_o} !== {1'b1, 8'd1}) begin
            fails++;
            $display("[TB] FAIL bubble_count: flag/cnt got %b/%0d required 1/1", bus.errFlag_o, bus.errCnt_o);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus.err_o, bus.errFlag_o} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL err_pulse_width: err/flag got %b/%b required 0/1", bus.err_o, bus.errFlag_o);
        end
        bus.clrErr_i = 1'b1;
        @(posedge clk); #1;
        bus.clrErr_i = 1'b0;
        tests++;
        if ({bus.errFlag_o, bus.errCnt_o} !== 9'd0) begin
            fails++;
            $display("[TB] FAIL clr_idle: flag/cnt got %b/%0d required 0/0", bus.errFlag_o, bus.errCnt_o);
        end
        applyStimulus("all_ones",    16'hFFFF, 4'd5, 2'd3, 1'b0, 1'b0, 1'b1);
        tests++;
        if (bus.errCnt_o !== 8'd1) begin
            fails++;
            $display("[TB] FAIL all_ones_count: got %0d required 1", bus.errCnt_o);
        end
    endtask

    task automatic test_jump_then_down();
        applyStimulus("load_2",      therm(2), 4'd2, 2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("jump_9",      therm(9), 4'd9, 2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("down_8",      therm(8), 4'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        bus.tCount_i = 16'h0005;
        for (int i = 0; i < 260; i++) waitTick();
        tests++;
        if ({bus.errFlag_o, bus.errCnt_o, bus.binCount_o, bus.dir_o} !== {1'b1, 8'd255, 4'd8, 2'd2}) begin
            fails++;
            $display("[TB] FAIL saturate: flag/cnt/bin/dir got %b/%0d/%0d/%0d required 1/255/8/2",
                     bus.errFlag_o, bus.errCnt_o, bus.binCount_o, bus.dir_o);
        end
        bus.clrErr_i = 1'b1;
        waitTick();
        bus.clrErr_i = 1'b0;
        tests++;
        if ({bus.errFlag_o, bus.errCnt_o, bus.err_o} !== {1'b1, 8'd1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL clr_with_error: flag/cnt/err got %b/%0d/%b required 1/1/1",
                     bus.errFlag_o, bus.errCnt_o, bus.err_o);
        end
    endtask

    task automatic test_reset_mid_sample();
        bus.tCount_i = therm(7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        tests++;
        if ({bus.binCount_o, bus.dir_o, bus.errFlag_o, bus.errCnt_o, bus.err_o} !== 16'd0) begin
            fails++;
            $display("[TB] FAIL mid_reset: bin/dir/flag/cnt got %0d/%0d/%b/%0d required 0/0/0/0",
                     bus.binCount_o, bus.dir_o, bus.errFlag_o, bus.errCnt_o);
        end
        @(negedge clk) rst_n = 1'b1;
        applyStimulus("resync_15",   16'h7FFF, 4'd15, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("resync_wrap", 16'h0000, 4'd0,  2'd1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sync_and_up_wrap();
        test_bounce();
        test_error();
        test_jump_then_down();
        test_saturation();
        test_reset_mid_sample();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
